data_memory_responder: RTL and testbench

Responder side of the machine's data-memory request/ready handshake: accepts one load/store request at a time from the CPU core, models a configurable number of wait states, then performs the access on an internal word-organised RAM and returns a one-cycle ready pulse with read data. It is instantiated beside `machine` in benches and SOPC builds as the target that answers the core's memory stage.

---
 rtl/data_memory_responder.sv | 127 ++++++++++++
 tb/tb_data_memory_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory request/ready responder with wait states and word RAM
module data_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request_enable,
    input  logic        request_write,
    input  logic [31:0] request_address,
    input  logic [3:0]  request_select,
    input  logic [31:0] request_data,
    output logic        response_ready,
    output logic [31:0] response_data,
    output logic        response_error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  out_of_range;
    logic                  access;
    logic                  mem_we;

    assign word_idx     = addr_q[ADDR_WIDTH+1:2];
    // A full-word access must be word aligned; narrower lane sets may carry low address bits.
    assign out_of_range = ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0) ||
                          ((addr_q[1:0] != 2'b00) && (sel_q == 4'b1111));
    assign access       = (state_q == BUSY) && (count_q == 4'd0);
    assign mem_we       = access && write_q && !out_of_range;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        write_d = write_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (request_enable) begin
                    write_d = request_write;
                    addr_d  = request_address;
                    sel_d   = request_select;
                    wdata_d = request_data;
                    count_d = 4'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    state_d = RESPOND;
                    if (out_of_range) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else begin
                        rdata_d = write_q ? 32'h0 : mem[word_idx];
                        err_d   = 1'b0;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            sel_q   <= 4'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM keeps its contents across reset; writes are gated by state, so reset drops a pending store.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign response_ready = ready_q;
    assign response_data  = rdata_q;
    assign response_error = err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder
module tb_data_memory_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #10 clock = ~clock;

    logic        en = 1'b0, wr = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        rdy, rerr;
    logic [31:0] rdata;

    logic        en0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
    logic [3:0]  sel0 = 4'h0;
    logic        rdy0, rerr0;
    logic [31:0] rdata0;

    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .request_enable(en), .request_write(wr), .request_address(addr),
        .request_select(sel), .request_data(wdata),
        .response_ready(rdy), .response_data(rdata), .response_error(rerr)
    );

    data_memory_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
        .clock(clock), .reset(reset),
        .request_enable(en0), .request_write(wr0), .request_address(addr0),
        .request_select(sel0), .request_data(wdata0),
        .response_ready(rdy0), .response_data(rdata0), .response_error(rerr0)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          cyc = 0;
    logic [32:0] sb2[$];
    logic [32:0] sb0[$];

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rdy === 1'b1) begin
            logic [32:0] e;
            if (sb2.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb2.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rerr", {31'b0, rerr}, {31'b0, e[32]});
            end
        end
    end

    always @(negedge clock) begin
        if (rdy0 === 1'b1) begin
            logic [32:0] e;
            if (sb0.size() == 0) begin
                chk("unexpected_ready0", 32'd1, 32'd0);
            end else begin
                e = sb0.pop_front();
                chk("rdata0", rdata0, e[31:0]);
                chk("rerr0", {31'b0, rerr0}, {31'b0, e[32]});
            end
        end
    end

    // Drives one request from a negedge, optionally switching address/data one cycle after acceptance.
    task automatic do_req(input string tag, input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] a_alt,
                          input logic [31:0] exp_d, input logic exp_e);
        int c0;
        int n;
        sb2.push_back({exp_e, exp_d});
        en = 1'b1; wr = w; addr = a; sel = s; wdata = d;
        @(posedge clock);
        @(negedge clock);
        c0 = cyc;
        addr = a_alt; wdata = ~d;
        n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("latency_%s", tag), cyc - c0, 32'd3);
        en = 1'b0;
        @(negedge clock);
        chk($sformatf("pulse_%s", tag), {31'b0, rdy}, 32'd0);
    endtask

    initial begin
        int c0, t1, t2, npulse;

        #100;
        chk("reset_ready", {31'b0, rdy}, 32'd0);
        chk("reset_data", rdata, 32'h0);
        chk("reset_error", {31'b0, rerr}, 32'd0);
        chk("reset_ready0", {31'b0, rdy0}, 32'd0);
        #95 reset = 1'b0;
        @(negedge clock);

        do_req("st_beef", 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 32'h40, 32'h0, 1'b0);
        do_req("ld_beef", 1'b0, 32'h40, 4'hF, 32'h0, 32'h40, 32'hDEADBEEF, 1'b0);

        do_req("st_full", 1'b1, 32'h80, 4'hF, 32'h11223344, 32'h80, 32'h0, 1'b0);
        do_req("st_lanes", 1'b1, 32'h80, 4'h5, 32'hAABBCCDD, 32'h80, 32'h0, 1'b0);
        do_req("ld_lanes", 1'b0, 32'h80, 4'hF, 32'h0, 32'h80, 32'h11BB33DD, 1'b0);

        do_req("st_zero", 1'b1, 32'h0, 4'hF, 32'h12345678, 32'h0, 32'h0, 1'b0);
        do_req("ld_oor", 1'b0, 32'h1000, 4'hF, 32'h0, 32'h1000, 32'h0, 1'b1);
        do_req("st_oor", 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h1000, 32'h0, 1'b1);
        do_req("ld_zero", 1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 32'h12345678, 1'b0);
        do_req("ld_misalign", 1'b0, 32'h41, 4'hF, 32'h0, 32'h41, 32'h0, 1'b1);
        do_req("ld_lane_ofs", 1'b0, 32'h41, 4'h1, 32'h0, 32'h41, 32'hDEADBEEF, 1'b0);
        do_req("st_nosel", 1'b1, 32'h40, 4'h0, 32'h0, 32'h40, 32'h0, 1'b0);
        do_req("ld_nosel", 1'b0, 32'h40, 4'hF, 32'h0, 32'h40, 32'hDEADBEEF, 1'b0);

        do_req("st_seven", 1'b1, 32'h8, 4'hF, 32'h7, 32'h8, 32'h0, 1'b0);
        do_req("ld_seven", 1'b0, 32'h8, 4'hF, 32'h0, 32'h8, 32'h7, 1'b0);
        en = 1'b1; wr = 1'b1; addr = 32'h8; sel = 4'hF; wdata = 32'h5;
        @(posedge clock);
        @(negedge clock);
        en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset_data", rdata, 32'h0);
        chk("midreset_error", {31'b0, rerr}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("midreset_ready", {31'b0, rdy}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        do_req("ld_after_reset", 1'b0, 32'h8, 4'hF, 32'h0, 32'h8, 32'h7, 1'b0);

        do_req("st_10", 1'b1, 32'h10, 4'hF, 32'h00001010, 32'h10, 32'h0, 1'b0);
        do_req("st_20", 1'b1, 32'h20, 4'hF, 32'h00002020, 32'h20, 32'h0, 1'b0);
        do_req("ld_switch", 1'b0, 32'h10, 4'hF, 32'h0, 32'h20, 32'h00001010, 1'b0);
        do_req("st_switch", 1'b1, 32'h30, 4'hF, 32'h0000BEEF, 32'h20, 32'h0, 1'b0);
        do_req("ld_30", 1'b0, 32'h30, 4'hF, 32'h0, 32'h30, 32'h0000BEEF, 1'b0);
        do_req("ld_20", 1'b0, 32'h20, 4'hF, 32'h0, 32'h20, 32'h00002020, 1'b0);

        sb0.push_back({1'b0, 32'h0});
        sb0.push_back({1'b0, 32'hA5A55A5A});
        en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h4; sel0 = 4'hF; wdata0 = 32'hA5A55A5A;
        @(posedge clock);
        @(negedge clock);
        c0 = cyc;
        wr0 = 1'b0; wdata0 = 32'h0;
        t1 = -1; t2 = -1; npulse = 0;
        for (int k = 0; k < 12; k++) begin
            if (rdy0 === 1'b1) begin
                npulse++;
                if (t1 < 0) begin
                    t1 = cyc - c0;
                end else if (t2 < 0) begin
                    t2 = cyc - c0;
                    en0 = 1'b0;
                end
            end
            @(negedge clock);
        end
        en0 = 1'b0;
        chk("lat0_first_pulse", t1, 32'd1);
        chk("lat0_second_pulse", t2, 32'd4);
        chk("lat0_pulse_count", npulse, 32'd2);

        repeat (3) @(negedge clock);
        chk("sb2_drained", sb2.size(), 32'd0);
        chk("sb0_drained", sb0.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
